// File: rtl/float_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : float_addsub_pipe
// Brief    : 3-stage pipelined single-precision add/subtract (truncating,
//            no NaN/Inf/denormals) with valid/ready flow control.
// Revision : 1.0
// ============================================================================
module float_addsub_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] c_exp_max = 8'hFE;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // ---------------- stage registers ----------------
  logic        r_v1, r_v2, r_v3;
  logic        r1_sign, r1_eff_sub;
  logic [7:0]  r1_exp;
  logic [23:0] r1_sig_l, r1_sig_s;
  logic        r2_sign;
  logic [7:0]  r2_exp;
  logic [24:0] r2_sum;
  logic [31:0] r_result;

  // ---------------- flow control ----------------
  logic w_adv1, w_adv2, w_adv3;
  assign w_adv3    = !r_v3 || out_ready;
  assign w_adv2    = !r_v2 || w_adv3;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = rst_n && w_adv1;
  assign out_valid = r_v3;
  assign result    = r_result;

  // ---------------- S1: decode and align ----------------
  // A zero exponent zeroes the whole magnitude so it never wins the compare.
  logic [30:0] w_mag_a, w_mag_b, w_mag_l, w_mag_s;
  logic        w_sign_b, w_swap, w_sign_l, w_eff_sub;
  logic [7:0]  w_d;
  logic [23:0] w_sig_l, w_sig_s, w_sig_s_sh;

  assign w_mag_a    = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
  assign w_mag_b    = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
  assign w_sign_b   = b[31] ^ sub;
  assign w_swap     = w_mag_b > w_mag_a;
  assign w_mag_l    = w_swap ? w_mag_b : w_mag_a;
  assign w_mag_s    = w_swap ? w_mag_a : w_mag_b;
  assign w_sign_l   = w_swap ? w_sign_b : a[31];
  assign w_eff_sub  = a[31] ^ w_sign_b;
  assign w_sig_l    = {(w_mag_l[30:23] != 8'd0), w_mag_l[22:0]};
  assign w_sig_s    = {(w_mag_s[30:23] != 8'd0), w_mag_s[22:0]};
  assign w_d        = w_mag_l[30:23] - w_mag_s[30:23];
  assign w_sig_s_sh = (w_d >= 8'd25) ? 24'd0 : (w_sig_s >> w_d);

  // ---------------- S3: normalize ----------------
  logic [4:0]  w_lz;
  logic [8:0]  w_exp_up;
  logic [23:0] w_norm;
  logic [31:0] w_res;

  assign w_lz     = lzc24(r2_sum[23:0]);
  assign w_exp_up = {1'b0, r2_exp} + 9'd1;

  always_comb begin
    w_res  = 32'd0;
    w_norm = r2_sum[23:0] << w_lz;
    if (r2_sum[24]) begin
      if (w_exp_up >= 9'd255) w_res = {r2_sign, c_exp_max, 23'h7FFFFF};
      else                    w_res = {r2_sign, w_exp_up[7:0], r2_sum[23:1]};
    end else if (r2_sum[23:0] != 24'd0 && r2_exp > {3'd0, w_lz}) begin
      w_res = {r2_sign, r2_exp - {3'd0, w_lz}, w_norm[22:0]};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r1_sign    <= 1'b0;
      r1_eff_sub <= 1'b0;
      r1_exp     <= 8'd0;
      r1_sig_l   <= 24'd0;
      r1_sig_s   <= 24'd0;
      r2_sign    <= 1'b0;
      r2_exp     <= 8'd0;
      r2_sum     <= 25'd0;
      r_result   <= 32'd0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r1_sign    <= w_sign_l;
          r1_eff_sub <= w_eff_sub;
          r1_exp     <= w_mag_l[30:23];
          r1_sig_l   <= w_sig_l;
          r1_sig_s   <= w_sig_s_sh;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r2_sign <= r1_sign;
          r2_exp  <= r1_exp;
          // After the swap sig_l >= sig_s, so the difference never goes negative.
          r2_sum  <= r1_eff_sub ? ({1'b0, r1_sig_l} - {1'b0, r1_sig_s})
                                : ({1'b0, r1_sig_l} + {1'b0, r1_sig_s});
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) r_result <= w_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_addsub_pipe
// Brief    : Directed, table-driven self-checking bench for float_addsub_pipe.
// Revision : 1.0
// ============================================================================
module tb_float_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;

  float_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] got[$];
  logic        mon_en = 1'b0;
  logic        saw_not_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic void addv(input logic [31:0] va, input logic [31:0] vb,
                               input logic vs, input logic [31:0] ve, input string n);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.exp = ve; v.name = n;
    vq.push_back(v);
  endfunction

  // Drive one op from #1 after a posedge; returns #1 after its accepting edge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vs);
    bit ok = 0;
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input vec_t v);
    bit ok = 0;
    send(v.a, v.b, v.sub);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", v.name);
    end else begin
      chk(v.name, result, v.exp);
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: collects transfers and checks hold-while-stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!in_ready) saw_not_ready = 1'b1;
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("stall_result_hold", result, prev_res);
      end
      if (out_valid && out_ready) got.push_back(result);
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int stale;
    addv(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, "one_minus_075");
    addv(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, "exact_cancel");
    addv(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, "d30_shift_out");
    addv(32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, "zero_plus_neg3");
    addv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, "saturate");
    addv(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, "one_minus_two");
    addv(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, "negzero_plus_zero");
    addv(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, "three_plus_one");
    addv(32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, "underflow");
    addv(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, "d23_keep_lsb");
    addv(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "d24_truncate");
    addv(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF, "carry_truncate");
    addv(32'h00123456, 32'h3F800000, 1'b0, 32'h3F800000, "zero_exp_garbage");
    addv(32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, "sub_negative_b");

    // Reset state
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency of 3 and a single-cycle out_valid pulse
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_c2_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_c3_result", result, 32'h40000000);
    @(posedge clk); #1;
    chk("lat_c4_valid", {31'd0, out_valid}, 32'd0);

    // Table of single operations
    foreach (vq[i]) run_one(vq[i]);

    // Stream of 6 with a 4-cycle output stall mid-stream
    got.delete();
    saw_not_ready = 1'b0;
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vq[i].a, vq[i].b, vq[i].sub);
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 30 && got.size() < 6; k++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("stream_count", got.size(), 32'd6);
    chk("stream_in_ready_dropped", {31'd0, saw_not_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("stream_%0d", i), got[i], vq[i].exp);
    end

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_result", result, 32'd0);
    chk("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_output", stale, 32'd0);
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h3F400000; sub = 1'b1; in_valid = 1'b1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("post_reset_c1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("post_reset_c2", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("post_reset_c3", {31'd0, out_valid}, 32'd1);
    chk("post_reset_result", result, 32'h3E800000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
